eeprom_spi_rx: RTL

- Serial receiver at the far end of the EEPROM write-back link.
- Deserialises frames in the same format the EEPROM emulation shifts out: active-low select, then a 16-bit command, MSB first, then an optional 16-bit data word.
- Decodes the command against the configured EEPROM size and replays it as a sequence of word writes into a mirror memory on the receiving side.
- Used on the MCU-bridge side and as the loopback checker for the write-back path.

---
 rtl/eeprom_spi_rx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/eeprom_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_spi_rx
// Brief    : Deserialises EEPROM-format frames and replays them as mirror writes.
// Revision : 1.0
// ============================================================================
module eeprom_spi_rx #(
    parameter int ADDR_W = 10
) (
    input  logic              SClk,
    input  logic              Reset,
    input  logic [1:0]        EEPROMSize,
    input  logic              SPISel,
    input  logic              SPIClkRunning,
    input  logic              SPIDi,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       MemData,
    output logic              Busy,
    output logic              FrameDone,
    output logic              FrameError,
    output logic              Overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE1 = 2'd1,
        S_SWEEP  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_IGNORE = 3'd0,
        K_WRITE  = 3'd1,
        K_WRALL  = 3'd2,
        K_ERASE  = 3'd3,
        K_ERALL  = 3'd4
    } kind_t;

    localparam logic [5:0] CNT_MAX = 6'd33;

    state_t              state_q, state_d;
    logic                sel_q;
    logic [5:0]          cnt_q, cnt_d;
    logic [31:0]         sr_q, sr_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   mask_q, mask_d;
    logic [15:0]         data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ovr_q, ovr_d;

    logic                w_sample, w_fall, w_end;
    logic [15:0]         w_cmd;
    logic [4:0]          w_op;
    kind_t               w_kind;
    logic [5:0]          w_explen;
    logic [ADDR_W-1:0]   w_mask;
    logic                unused_cmd_hi;

    assign w_sample = !SPISel && SPIClkRunning;
    assign w_fall   = sel_q && !SPISel;
    assign w_end    = !sel_q && SPISel;

    // Bit counter and shift register; the command is captured as its 16th bit lands
    // so that truncated or over-long frames still decode their own opcode.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        cmd_d = cmd_q;
        if (w_fall) begin
            cnt_d = w_sample ? 6'd1 : 6'd0;
            cmd_d = '0;
        end else if (w_sample) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 6'd1;
            end
            if (cnt_q == 6'd15) begin
                cmd_d = {sr_q[14:0], SPIDi};
            end
        end
        if (w_sample) begin
            sr_d = {sr_q[30:0], SPIDi};
        end
    end

    assign w_cmd         = (cnt_q == 6'd32) ? sr_q[31:16] : cmd_q;
    assign w_op          = (EEPROMSize == 2'd0) ? w_cmd[8:4] : w_cmd[12:8];
    assign unused_cmd_hi = ^w_cmd[15:13];

    always_comb begin
        w_kind = K_IGNORE;
        casez (w_op)
            5'b101??: w_kind = K_WRITE;
            5'b10001: w_kind = K_WRALL;
            5'b111??: w_kind = K_ERASE;
            5'b10010: w_kind = K_ERALL;
            default:  w_kind = K_IGNORE;
        endcase
    end

    assign w_explen = (w_kind == K_WRITE || w_kind == K_WRALL) ? 6'd32 : 6'd16;

    always_comb begin
        case (EEPROMSize)
            2'd0:    w_mask = ADDR_W'(10'h03F);
            2'd1:    w_mask = ADDR_W'(10'h1FF);
            default: w_mask = ADDR_W'(10'h3FF);
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_WRITE1: state_d = S_IDLE;
            S_SWEEP: begin
                if (addr_q == mask_q) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = state_q;
        endcase

        // Frame end is only judged against Busy; a frame may be shifted in meanwhile.
        if (w_end && cnt_q != 6'd0) begin
            if (state_q != S_IDLE) begin
                ovr_d = 1'b1;
            end else if (w_kind != K_IGNORE && cnt_q != w_explen) begin
                err_d = 1'b1;
            end else begin
                done_d = 1'b1;
                if (w_kind != K_IGNORE && EEPROMSize != 2'd3) begin
                    mask_d = w_mask;
                    data_d = (w_kind == K_ERASE || w_kind == K_ERALL) ? 16'hFFFF : sr_q[15:0];
                    if (w_kind == K_WRITE || w_kind == K_ERASE) begin
                        addr_d  = w_cmd[ADDR_W-1:0] & w_mask;
                        state_d = S_WRITE1;
                    end else begin
                        addr_d  = '0;
                        state_d = S_SWEEP;
                    end
                end
            end
        end
    end

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b1;
            cnt_q   <= '0;
            sr_q    <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= SPISel;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign MemWrite   = Busy;
    assign MemAddr    = MemWrite ? addr_q : '0;
    assign MemData    = MemWrite ? data_q : '0;
    assign FrameDone  = done_q;
    assign FrameError = err_q;
    assign Overrun    = ovr_q;

endmodule
`default_nettype wire
